// File: rtl/obs_pkg.sv
// -----------------------------------------------------------------------------
// obs_pkg
// Shared definitions for the obstacle sprite path (ROM, fetch, mixer).
//   SPRITE_W / SPRITE_H : sprite size in texels (powers of 2)
//   SCALE               : screen pixels per texel edge (power of 2, >= 2)
//   ADDR_W              : sprite ROM address width, log2(SPRITE_W*SPRITE_H)
//   obs_state_e         : fetch FSM encoding
// -----------------------------------------------------------------------------
package obs_pkg;

   localparam int SPRITE_W = 2;
   localparam int SPRITE_H = 4;
   localparam int SCALE    = 8;
   localparam int ADDR_W   = 3;

   typedef enum logic [1:0] {
      OBS_IDLE = 2'd0,
      OBS_DRAW = 2'd1,
      OBS_DONE = 2'd2
   } obs_state_e;

endpackage

// File: rtl/obs_sprite_fetch.sv
// -----------------------------------------------------------------------------
// obs_sprite_fetch
// Reader side of the obstacle sprite ROM. Follows the beam, decides when the
// current pixel falls inside the obstacle box, drives the texel address and
// returns a registered obstacle pixel to the mixer. Each texel covers a
// SCALE x SCALE block of screen pixels.
//
// Ports
//   clk            in   pixel clock
//   rst            in   synchronous reset, active-high
//   i_hpos         in   beam column, +1 per valid pixel
//   i_vpos         in   beam row
//   i_pix_valid    in   visible-area strobe; everything holds when low
//   i_obs_x        in   obstacle left edge, sampled at the start of a line
//   i_obs_y        in   obstacle top edge, sampled at the start of a line
//   i_sprite_color in   texel at o_rom_counter (combinational ROM read)
//   o_rom_counter  out  texel address {row, col}
//   o_obs_pixel    out  obstacle pixel lit
//   o_obs_active   out  pixel lies inside the obstacle box
//
// Timing: hpos==obs_x sampled on edge N moves the FSM into DRAW; the outputs
// register "was DRAW" on edge N+1, so the mixer sees them two clocks after
// the matching hpos.
// -----------------------------------------------------------------------------
module obs_sprite_fetch #(
   parameter int POS_W    = 10,
   parameter int SPRITE_W = obs_pkg::SPRITE_W,
   parameter int SPRITE_H = obs_pkg::SPRITE_H,
   parameter int SCALE    = obs_pkg::SCALE,
   parameter int ADDR_W   = obs_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [POS_W-1:0]  i_hpos,
   input  logic [POS_W-1:0]  i_vpos,
   input  logic              i_pix_valid,
   input  logic [POS_W-1:0]  i_obs_x,
   input  logic [POS_W-1:0]  i_obs_y,
   input  logic              i_sprite_color,
   output logic [ADDR_W-1:0] o_rom_counter,
   output logic              o_obs_pixel,
   output logic              o_obs_active
);

   import obs_pkg::*;

   localparam int COL_W        = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
   localparam int ROW_W        = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
   localparam int SUB_W        = $clog2(SCALE);
   localparam int SPRITE_PIX_H = SPRITE_H * SCALE;

   obs_state_e        state_q, state_d;
   obs_state_e        step_state;
   logic [COL_W-1:0]  col_q, col_d;
   logic [SUB_W-1:0]  sub_x_q, sub_x_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic              row_in_range_q, row_in_range_d;
   logic [POS_W-1:0]  obs_x_q, obs_x_d;
   logic [ADDR_W-1:0] rom_counter_q, rom_counter_d;
   logic              obs_pixel_q, obs_pixel_d;
   logic              obs_active_q, obs_active_d;

   logic              line_latch;
   logic [POS_W-1:0]  dy;

   assign line_latch = i_pix_valid && (i_hpos == '0);
   // Only meaningful on the latch cycle, where the new top edge is on i_obs_y.
   // The vertical position is reduced to (row, in-range) once per line, so the
   // top edge itself does not need to be kept after the latch.
   assign dy = i_vpos - i_obs_y;

   always_comb begin
      state_d        = state_q;
      col_d          = col_q;
      sub_x_d        = sub_x_q;
      row_d          = row_q;
      row_in_range_d = row_in_range_q;
      obs_x_d        = obs_x_q;
      rom_counter_d  = rom_counter_q;
      obs_pixel_d    = 1'b0;
      obs_active_d   = 1'b0;
      step_state     = state_q;

      if (i_pix_valid) begin
         obs_active_d = (state_q == OBS_DRAW);
         obs_pixel_d  = (state_q == OBS_DRAW) && i_sprite_color;

         if (line_latch) begin
            obs_x_d        = i_obs_x;
            // The >= compare rejects a wrapped subtraction when the beam is
            // above the obstacle.
            row_in_range_d = (i_vpos >= i_obs_y) && (dy < POS_W'(SPRITE_PIX_H));
            row_d          = dy[SUB_W +: ROW_W];
            // A new line cancels any run still in progress (right-edge clip)
            // and re-arms the FSM; the IDLE check below then sees the freshly
            // latched values so obs_x==0 starts on this very cycle.
            step_state     = OBS_IDLE;
         end

         unique case (step_state)
            OBS_IDLE: begin
               state_d = OBS_IDLE;
               if (row_in_range_d && (i_hpos == obs_x_d)) begin
                  state_d       = OBS_DRAW;
                  col_d         = '0;
                  sub_x_d       = '0;
                  rom_counter_d = ADDR_W'({row_d, col_d});
               end
            end
            OBS_DRAW: begin
               sub_x_d = sub_x_q + 1'b1;
               if (sub_x_q == SUB_W'(SCALE - 1)) begin
                  sub_x_d = '0;
                  col_d   = col_q + 1'b1;
                  if (col_q == COL_W'(SPRITE_W - 1)) begin
                     state_d = OBS_DONE;
                  end
               end
               rom_counter_d = ADDR_W'({row_q, col_d});
            end
            OBS_DONE: begin
               // Held until the next line latch: one run per line.
               state_d = OBS_DONE;
            end
            default: begin
               state_d = OBS_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= OBS_IDLE;
         col_q          <= '0;
         sub_x_q        <= '0;
         row_q          <= '0;
         row_in_range_q <= 1'b0;
         obs_x_q        <= '0;
         rom_counter_q  <= '0;
         obs_pixel_q    <= 1'b0;
         obs_active_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         col_q          <= col_d;
         sub_x_q        <= sub_x_d;
         row_q          <= row_d;
         row_in_range_q <= row_in_range_d;
         obs_x_q        <= obs_x_d;
         rom_counter_q  <= rom_counter_d;
         obs_pixel_q    <= obs_pixel_d;
         obs_active_q   <= obs_active_d;
      end
   end

   assign o_rom_counter = rom_counter_q;
   assign o_obs_pixel   = obs_pixel_q;
   assign o_obs_active  = obs_active_q;

endmodule

// File: tb/tb_obs_sprite_fetch.sv
// -----------------------------------------------------------------------------
// tb_obs_sprite_fetch
// Directed bench for obs_sprite_fetch. Scans whole lines, attributes each
// registered output to the pixel it belongs to (the hpos applied one cycle
// before the edge that produced it, i.e. the mixer's hpos delayed by 2) and
// compares per-line statistics with hand-computed values.
// -----------------------------------------------------------------------------
module tb_obs_sprite_fetch;

   localparam int POS_W  = 10;
   localparam int LINE_W = 400;

   logic             clk = 1'b0;
   logic             rst;
   logic [POS_W-1:0] hpos, vpos, obs_x, obs_y;
   logic             pix_valid;
   logic             sprite_color;
   logic [2:0]       rom_counter;
   logic             obs_pixel;
   logic             obs_active;

   // Every sprite row is 2'b01: column 0 lit, column 1 dark.
   logic [7:0]       rom_bits = 8'b0101_0101;

   int n_checks = 0;
   int n_errors = 0;

   int         prev_h;
   int         n_act, first_act, last_act;
   int         n_lit, first_lit, last_lit;
   int         n_gap_act, n_post_rst_act;
   logic [7:0] addr_mask;
   logic       post_rst;

   always #5 clk = ~clk;

   assign sprite_color = rom_bits[rom_counter];

   obs_sprite_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .i_hpos         (hpos),
      .i_vpos         (vpos),
      .i_pix_valid    (pix_valid),
      .i_obs_x        (obs_x),
      .i_obs_y        (obs_y),
      .i_sprite_color (sprite_color),
      .o_rom_counter  (rom_counter),
      .o_obs_pixel    (obs_pixel),
      .o_obs_active   (obs_active)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // One clock: drive inputs, take the edge, sample 1 time unit later.
   task automatic cycle(input int h, input int v, input logic valid, input logic r);
      hpos      = POS_W'(h);
      vpos      = POS_W'(v);
      pix_valid = valid;
      rst       = r;
      @(posedge clk);
      #1;
      if (r) post_rst = 1'b1;
      if (obs_active) begin
         n_act++;
         if (first_act < 0) first_act = prev_h;
         last_act = prev_h;
         addr_mask[rom_counter] = 1'b1;
         if (!valid) n_gap_act++;
         if (post_rst && !r) n_post_rst_act++;
      end
      if (obs_pixel) begin
         n_lit++;
         if (first_lit < 0) first_lit = prev_h;
         last_lit = prev_h;
      end
      prev_h = h;
   endtask

   // Scan one line. x0 is presented before hpos chg_at, x1 from then on.
   // gap_at inserts 5 invalid cycles before that hpos; rst_at pulses reset.
   task automatic run_line(input int v, input int y, input int x0, input int x1,
                           input int chg_at, input int gap_at, input int rst_at);
      n_act = 0; first_act = -1; last_act = -1;
      n_lit = 0; first_lit = -1; last_lit = -1;
      n_gap_act = 0; n_post_rst_act = 0;
      addr_mask = 8'h00;
      post_rst  = 1'b0;
      prev_h    = -1;
      obs_y     = POS_W'(y);
      for (int h = 0; h < LINE_W; h++) begin
         obs_x = (h < chg_at) ? POS_W'(x0) : POS_W'(x1);
         if (h == gap_at) begin
            for (int g = 0; g < 5; g++) cycle(h, v, 1'b0, 1'b0);
         end
         if (h == rst_at) begin
            cycle(h, v, 1'b1, 1'b1);
            check("rst_mid_active", 32'(obs_active), 32'd0);
            check("rst_mid_pixel", 32'(obs_pixel), 32'd0);
            check("rst_mid_addr", 32'(rom_counter), 32'd0);
         end else begin
            cycle(h, v, 1'b1, 1'b0);
         end
      end
      for (int b = 0; b < 4; b++) cycle(LINE_W, v, 1'b0, 1'b0);
      $display("line vpos=%0d obs=(%0d->%0d,%0d) act=%0d [%0d..%0d] lit=%0d [%0d..%0d] addr_mask=%b",
               v, x0, x1, y, n_act, first_act, last_act, n_lit, first_lit, last_lit, addr_mask);
   endtask

   initial begin
      rst = 1'b1; pix_valid = 1'b0;
      hpos = '0; vpos = '0; obs_x = '0; obs_y = '0;

      // Reset with random inputs.
      for (int i = 0; i < 3; i++) begin
         hpos      = POS_W'($urandom_range(1023));
         vpos      = POS_W'($urandom_range(1023));
         obs_x     = POS_W'($urandom_range(1023));
         obs_y     = POS_W'($urandom_range(1023));
         pix_valid = 1'($urandom_range(1));
         rst       = 1'b1;
         @(posedge clk);
         #1;
         check("reset_active", 32'(obs_active), 32'd0);
         check("reset_pixel", 32'(obs_pixel), 32'd0);
         check("reset_addr", 32'(rom_counter), 32'd0);
      end
      rst = 1'b0;

      // Row 0 of the sprite.
      run_line(200, 200, 100, 100, 0, -1, -1);
      check("row0_act_count", 32'(n_act), 32'd16);
      check("row0_act_first", 32'(first_act), 32'd100);
      check("row0_act_last", 32'(last_act), 32'd115);
      check("row0_lit_count", 32'(n_lit), 32'd8);
      check("row0_lit_first", 32'(first_lit), 32'd100);
      check("row0_lit_last", 32'(last_lit), 32'd107);
      check("row0_addr_mask", 32'(addr_mask), 32'h03);

      // Row 1 (dy=15) and the last row (dy=31).
      run_line(215, 200, 100, 100, 0, -1, -1);
      check("row1_addr_mask", 32'(addr_mask), 32'h0C);
      run_line(231, 200, 100, 100, 0, -1, -1);
      check("row3_act_count", 32'(n_act), 32'd16);
      check("row3_lit_count", 32'(n_lit), 32'd8);
      check("row3_addr_mask", 32'(addr_mask), 32'hC0);

      // One row below the sprite, one row above it (wrapped dy).
      run_line(232, 200, 100, 100, 0, -1, -1);
      check("below_act_count", 32'(n_act), 32'd0);
      run_line(199, 200, 100, 100, 0, -1, -1);
      check("above_act_count", 32'(n_act), 32'd0);

      // Valid strobe dropped for 5 clocks in mid-run.
      run_line(200, 200, 100, 100, 0, 104, -1);
      check("gap_act_count", 32'(n_act), 32'd16);
      check("gap_act_while_invalid", 32'(n_gap_act), 32'd0);
      check("gap_lit_count", 32'(n_lit), 32'd8);
      check("gap_act_first", 32'(first_act), 32'd100);

      // Obstacle at the left edge starts on the latch cycle.
      run_line(200, 200, 0, 0, 0, -1, -1);
      check("x0_act_count", 32'(n_act), 32'd16);
      check("x0_act_first", 32'(first_act), 32'd0);
      check("x0_act_last", 32'(last_act), 32'd15);

      // Obstacle past the visible width is never drawn.
      run_line(200, 200, 500, 500, 0, -1, -1);
      check("offscreen_act_count", 32'(n_act), 32'd0);

      // Position change in mid-line takes effect on the next line.
      run_line(200, 200, 100, 300, 50, -1, -1);
      check("move_cur_act_count", 32'(n_act), 32'd16);
      check("move_cur_act_first", 32'(first_act), 32'd100);
      run_line(200, 200, 300, 300, 0, -1, -1);
      check("move_next_act_first", 32'(first_act), 32'd300);
      check("move_next_act_last", 32'(last_act), 32'd315);

      // Reset in mid-draw kills the rest of the line.
      run_line(200, 200, 100, 100, 0, -1, 110);
      check("rstmid_act_before", 32'(n_act), 32'd9);
      check("rstmid_act_after", 32'(n_post_rst_act), 32'd0);
      run_line(200, 200, 100, 100, 0, -1, -1);
      check("rstmid_next_act_count", 32'(n_act), 32'd16);
      check("rstmid_next_act_first", 32'(first_act), 32'd100);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
